// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NUM_REQ byte sources with
// round-robin arbitration and sequences each byte against tx_busy, so only one
// frame is in flight at a time.
// Optional build macro UART_ARB_LOCK_EN adds req_lock, which keeps a multi-byte
// message from one requester contiguous.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned IDX_W         = 2,
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data_in,
    output logic                 tx_data_valid,
    input  logic                 tx_busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 arb_busy,
    output logic                 err_timeout
);

    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [7:0]       req_byte [NUM_REQ];
    logic [IDX_W-1:0] cand;
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic             win_fire;
    logic [IDX_W-1:0] win_idx;

`ifdef UART_ARB_LOCK_EN
    logic lock_q;
    logic lock_clr;
`endif

    assign arb_busy = (state_q != StIdle);

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin search starting just after the last served requester.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Decide whether an arbitration fires this cycle and who wins it.
    always_comb begin
        win_fire = 1'b0;
        win_idx  = rr_idx;
`ifdef UART_ARB_LOCK_EN
        lock_clr = 1'b0;
`endif
        if (state_q == StIdle && !tx_busy) begin
`ifdef UART_ARB_LOCK_EN
            if (lock_q && req_lock[grant_idx]) begin
                // Locked: only the owner may win; an idle owner drops the lock.
                win_idx  = grant_idx;
                win_fire = req_valid[grant_idx];
                lock_clr = !req_valid[grant_idx];
            end else begin
                lock_clr = 1'b1;
                win_fire = rr_found;
            end
`else
            win_fire = rr_found;
`endif
        end
    end

    // Arbitration FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_q        <= IDX_LAST;
            cnt_q         <= '0;
            req_ready     <= '0;
            tx_data_in    <= 8'h00;
            tx_data_valid <= 1'b0;
            grant_idx     <= IDX_LAST;
            err_timeout   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q        <= 1'b0;
`endif
        end else begin
            req_ready     <= '0;
            tx_data_valid <= 1'b0;
            err_timeout   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (win_fire) begin
                        tx_data_in <= req_byte[win_idx];
                        grant_idx  <= win_idx;
                        req_ready  <= NUM_REQ'(1) << win_idx;
                        state_q    <= StIssue;
                    end
`ifdef UART_ARB_LOCK_EN
                    if (lock_clr) begin
                        lock_q <= 1'b0;
                    end
`endif
                end
                StIssue: begin
                    tx_data_valid <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= StWaitStart;
                end
                StWaitStart: begin
                    if (tx_busy) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CNT_LAST) begin
                        // Serializer never started: drop the byte, move on.
                        err_timeout <= 1'b1;
                        last_q      <= grant_idx;
                        state_q     <= StIdle;
`ifdef UART_ARB_LOCK_EN
                        lock_q      <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!tx_busy) begin
                        last_q  <= grant_idx;
                        state_q <= StIdle;
`ifdef UART_ARB_LOCK_EN
                        lock_q  <= req_lock[grant_idx];
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; tx_busy is driven by hand to stand in for uart_tx.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned IDX_W         = 2;
    localparam int unsigned START_TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   req_lock;
`endif
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data_in;
    logic                 tx_data_valid;
    logic                 tx_busy;
    logic [IDX_W-1:0]     grant_idx;
    logic                 arb_busy;
    logic                 err_timeout;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .IDX_W        (IDX_W),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock     (req_lock),
`endif
        .req_ready    (req_ready),
        .tx_data_in   (tx_data_in),
        .tx_data_valid(tx_data_valid),
        .tx_busy      (tx_busy),
        .grant_idx    (grant_idx),
        .arb_busy     (arb_busy),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_vals(input string tag);
        check({tag, ".ready"}, 32'(req_ready), 32'h0);
        check({tag, ".data"}, 32'(tx_data_in), 32'h0);
        check({tag, ".valid"}, 32'(tx_data_valid), 32'h0);
        check({tag, ".gidx"}, 32'(grant_idx), 32'd3);
        check({tag, ".abusy"}, 32'(arb_busy), 32'h0);
        check({tag, ".err"}, 32'(err_timeout), 32'h0);
    endtask

    // Entered in IDLE with the request presented; leaves in IDLE after a full frame.
    // After the grant the winner presents (nv, nd) as its next request.
    task automatic frame(input string tag, input int idx, input logic [7:0] dat,
                         input logic nv, input logic [7:0] nd);
        logic [1:0] i2;
        i2 = idx[1:0];
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'(1) << idx);
        check({tag, ".gidx"}, 32'(grant_idx), 32'(idx));
        check({tag, ".data"}, 32'(tx_data_in), 32'(dat));
        check({tag, ".err"}, 32'(err_timeout), 32'h0);
        req_valid[i2]               = nv;
        req_data[{i2, 3'b000} +: 8] = nd;
        @(negedge clk);
        check({tag, ".valid"}, 32'(tx_data_valid), 32'h1);
        check({tag, ".ready1"}, 32'(req_ready), 32'h0);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, ".valid0"}, 32'(tx_data_valid), 32'h0);
        check({tag, ".abusy"}, 32'(arb_busy), 32'h1);
        tx_busy = 1'b0;
        @(negedge clk);
        check({tag, ".idle"}, 32'(arb_busy), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (3) @(negedge clk);
        reset_vals("rst");
        rst = 1'b0;

        // Single request from requester 2.
        req_data[23:16] = 8'h55;
        req_valid       = 4'b0100;
        frame("t1", 2, 8'h55, 1'b0, 8'h00);

        // Timeout: requester 3 wins (last=2), tx_busy never rises.
        req_data[31:24] = 8'hA3;
        req_data[7:0]   = 8'hA0;
        req_valid       = 4'b1001;
        @(negedge clk);
        check("t4.ready", 32'(req_ready), 32'b1000);
        check("t4.gidx", 32'(grant_idx), 32'd3);
        req_valid[3] = 1'b0;
        @(negedge clk);
        check("t4.valid", 32'(tx_data_valid), 32'h1);
        repeat (START_TIMEOUT - 1) @(negedge clk);
        check("t4.err_early", 32'(err_timeout), 32'h0);
        check("t4.abusy_early", 32'(arb_busy), 32'h1);
        @(negedge clk);
        check("t4.err", 32'(err_timeout), 32'h1);
        check("t4.abusy", 32'(arb_busy), 32'h0);
        frame("t4.next", 0, 8'hA0, 1'b0, 8'h00);

        // Reset while in WAIT_DONE.
        req_data[15:8] = 8'h5A;
        req_valid      = 4'b0010;
        @(negedge clk);
        check("t5.ready", 32'(req_ready), 32'b0010);
        req_valid = '0;
        @(negedge clk);
        check("t5.valid", 32'(tx_data_valid), 32'h1);
        tx_busy = 1'b1;
        @(negedge clk);
        check("t5.abusy", 32'(arb_busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        reset_vals("t5");
        rst     = 1'b0;
        tx_busy = 1'b0;

        // Fairness: requesters 0 and 3 continuously valid.
        req_data[7:0]   = 8'hC0;
        req_data[31:24] = 8'hC3;
        req_valid       = 4'b1001;
        frame("t3a", 0, 8'hC0, 1'b1, 8'hC0);
        frame("t3b", 3, 8'hC3, 1'b1, 8'hC3);
        frame("t3c", 0, 8'hC0, 1'b1, 8'hC0);
        frame("t3d", 3, 8'hC3, 1'b0, 8'h00);
        req_valid = '0;

        // Contention: all four valid, each re-presents a second byte.
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        frame("t2a", 0, 8'h11, 1'b1, 8'h91);
        frame("t2b", 1, 8'h22, 1'b1, 8'h92);
        frame("t2c", 2, 8'h33, 1'b1, 8'h93);
        frame("t2d", 3, 8'h44, 1'b1, 8'h94);
        frame("t2e", 0, 8'h91, 1'b0, 8'h00);
        req_valid = '0;

        // Busy in IDLE blocks arbitration; tx_data_in holds the last byte.
        tx_busy         = 1'b1;
        req_data[23:16] = 8'h77;
        req_valid       = 4'b0100;
        @(negedge clk);
        check("hold.ready", 32'(req_ready), 32'h0);
        check("hold.data", 32'(tx_data_in), 32'h91);
        check("hold.abusy", 32'(arb_busy), 32'h0);
        tx_busy = 1'b0;
        frame("hold.go", 2, 8'h77, 1'b0, 8'h00);

`ifdef UART_ARB_LOCK_EN
        // Locked three-byte message from requester 1 while requester 0 waits.
        req_lock       = 4'b0010;
        req_data[15:8] = 8'hB1;
        req_valid      = 4'b0010;
        frame("t6a", 1, 8'hB1, 1'b1, 8'hB2);
        req_data[7:0] = 8'hB0;
        req_valid[0]  = 1'b1;
        frame("t6b", 1, 8'hB2, 1'b1, 8'hB3);
        frame("t6c", 1, 8'hB3, 1'b0, 8'h00);
        req_lock = '0;
        frame("t6d", 0, 8'hB0, 1'b0, 8'h00);
        req_valid = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte at a time from the granted requester and drives the uart_tx data_in/data_valid inputs.
- Sequences each byte against uart_tx busy, so that only one frame is in flight at a time.
- Sits between the message sources (command responder, status reporter, debug) and the single uart_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must equal clog2(NUM_REQ).
- START_TIMEOUT, 15, maximum number of cycles to wait for tx_busy to rise after issue.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-cycle, one-hot pulse; the byte of requester i is consumed this cycle.
- tx_data_in  output  8  byte to uart_tx data_in.
- tx_data_valid  output  1  one-cycle issue strobe to uart_tx data_valid.
- tx_busy  input  1  uart_tx busy.
- grant_idx  output  IDX_W  index of the requester that owns the current or last byte.
- arb_busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  one-cycle pulse; tx_busy did not rise within START_TIMEOUT.

Behaviour:
- Reset values:
  - req_ready=0, tx_data_in=0x00, tx_data_valid=0, grant_idx=NUM_REQ-1, arb_busy=0, err_timeout=0.
  - State = IDLE, timeout counter = 0.
  - Internal last pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - Arbitration runs when |req_valid and tx_busy==0.
  - Winner = first asserted req_valid searching last+1, last+2, ... modulo NUM_REQ.
  - Same cycle (registered at the edge): capture the winner's byte into tx_data_in, set grant_idx = winner, pulse req_ready[winner], go to ISSUE.
  - If tx_busy==1, stay in IDLE and assert no req_ready.
- ISSUE:
  - tx_data_valid=1 for exactly this one cycle, then go to WAIT_START.
  - Clear the timeout counter.
- WAIT_START:
  - tx_busy==1: go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches START_TIMEOUT: pulse err_timeout, set last=grant_idx, go to IDLE. The byte is dropped and not retried.
- WAIT_DONE:
  - When tx_busy==0: set last=grant_idx and go to IDLE.
  - The next arbitration can fire in the same cycle IDLE is entered, one cycle after busy falls.
- Latency:
  - req_valid high in IDLE at cycle N gives req_ready at N+1 and tx_data_valid at N+2.
  - Back-to-back bytes have 3 cycles of gap after busy falls.
- Requester handshake: a requester holds req_valid/req_data until it sees req_ready, then may present the next byte on the following cycle.
- tx_data_in holds its value until the next capture; it is not cleared on idle.
- Simultaneous requests: exactly one req_ready per arbitration; all others wait.
- Fairness: no requester is granted twice while another has held req_valid continuously.
- Deassertion: if a requester drops req_valid before being granted, it is simply skipped.
- Reset mid-operation: any state returns to IDLE next cycle with the reset values above. No strobe is issued, and the byte in flight is lost.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined: adds input port req_lock [NUM_REQ].
  - If req_lock[grant_idx] is high when WAIT_DONE exits, the next arbitration considers only that requester, so multi-byte messages are not interleaved.
  - The lock releases when req_lock[grant_idx] is low at arbitration time.
  - The lock also releases if the locked requester has req_valid low for 1 arbitration cycle in IDLE; normal round-robin then resumes.
- Undefined: no req_lock port; pure round-robin as above.

Test Plan:
1. Single request: after reset, req_valid[2]=1, data 0x55 -> req_ready=0b0100 one cycle later, tx_data_valid with tx_data_in=0x55 the cycle after, grant_idx=2; uart_tx emits frame 0x55.
2. Contention: all four req_valid high with 0x11/0x22/0x33/0x44, held until ready -> bytes issued in order 0x11, 0x22, 0x33, 0x44; exactly one req_ready per frame; second round starts at requester 0.
3. Round-robin fairness: requesters 0 and 3 continuously valid -> grants alternate 0, 3, 0, 3 over 4 frames.
4. Timeout: tx_busy tied 0 after issue -> err_timeout pulses exactly START_TIMEOUT cycles after entering WAIT_START; FSM is back in IDLE; next requester is granted.
5. Reset mid-frame: assert rst during WAIT_DONE -> next cycle all outputs are at reset values, grant_idx=3, and the next grant goes to requester 0.
6. With UART_ARB_LOCK_EN: requester 1 sends 3 bytes with req_lock[1]=1 while requester 0 is also valid -> the three requester-1 bytes are contiguous, then requester 0 is granted.
